// File: rtl/friscv_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// data load/store, with one access in flight and a completion watchdog.
module friscv_mem_arbiter #(
  parameter int ADDRW   = 16,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              srst,
  input  logic              inst_en,
  input  logic [ADDRW-1:0]  inst_addr,
  output logic [XLEN-1:0]   inst_rdata,
  output logic              inst_ready,
  output logic              inst_err,
  input  logic              data_en,
  input  logic              data_wr,
  input  logic [ADDRW-1:0]  data_addr,
  input  logic [XLEN-1:0]   data_wdata,
  input  logic [XLEN/8-1:0] data_strb,
  output logic [XLEN-1:0]   data_rdata,
  output logic              data_ready,
  output logic              data_err,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDRW-1:0]  mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_strb,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, INST, DATA} state_t;

  state_t      state, next_state, last_grant;
  logic [31:0] cnt;
  logic        grant_inst, grant_data, timeout, done;

  // On a tie the requester that did not own the previous access wins.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (state == IDLE) begin
      if (inst_en && data_en) begin
        if (last_grant == INST) grant_data = 1'b1;
        else                    grant_inst = 1'b1;
      end else begin
        grant_inst = inst_en;
        grant_data = data_en;
      end
    end
  end

  assign timeout = (TIMEOUT != 0) && (cnt == 32'(TIMEOUT));
  assign done    = (state != IDLE) && (mem_ready || timeout);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)  state <= IDLE;
    else if (srst) state <= IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_data)      next_state = DATA;
        else if (grant_inst) next_state = INST;
      end
      INST, DATA: if (done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // mem_ready wins over a timeout landing in the same cycle.
  always_comb begin
    inst_ready = (state == INST) && done;
    data_ready = (state == DATA) && done;
    inst_err   = (state == INST) && timeout && !mem_ready;
    data_err   = (state == DATA) && timeout && !mem_ready;
    inst_rdata = ((state == INST) && mem_ready) ? mem_rdata : '0;
    data_rdata = ((state == DATA) && mem_ready) ? mem_rdata : '0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_grant <= INST;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_strb   <= '0;
    end else if (srst) begin
      last_grant <= INST;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_strb   <= '0;
    end else begin
      if (done) last_grant <= state;

      if (grant_inst || grant_data)
        cnt <= '0;
      else if ((state != IDLE) && !mem_ready && (TIMEOUT != 0))
        cnt <= cnt + 32'd1;

      if (grant_data) begin
        mem_en    <= 1'b1;
        mem_wr    <= data_wr;
        mem_addr  <= data_addr;
        mem_wdata <= data_wdata;
        mem_strb  <= data_strb;
      end else if (grant_inst) begin
        mem_en    <= 1'b1;
        mem_wr    <= 1'b0;
        mem_addr  <= inst_addr;
        mem_wdata <= '0;
        mem_strb  <= '0;
      end else if (done) begin
        mem_en    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_friscv_mem_arbiter.sv
// Directed bench for friscv_mem_arbiter: fetch, store, tie alternation,
// watchdog abort and its boundary, and asynchronous reset mid-access.
module tb_friscv_mem_arbiter;

  localparam int ADDRW = 16;
  localparam int XLEN  = 32;

  logic              aclk = 1'b0;
  logic              aresetn, srst;
  logic              inst_en, inst_ready, inst_err;
  logic [ADDRW-1:0]  inst_addr;
  logic [XLEN-1:0]   inst_rdata;
  logic              data_en, data_wr, data_ready, data_err;
  logic [ADDRW-1:0]  data_addr;
  logic [XLEN-1:0]   data_wdata, data_rdata;
  logic [XLEN/8-1:0] data_strb;
  logic              mem_en, mem_wr, mem_ready;
  logic [ADDRW-1:0]  mem_addr;
  logic [XLEN-1:0]   mem_wdata, mem_rdata;
  logic [XLEN/8-1:0] mem_strb;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 aclk = ~aclk;

  friscv_mem_arbiter #(.ADDRW(ADDRW), .XLEN(XLEN), .TIMEOUT(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_ready(inst_ready), .inst_err(inst_err),
    .data_en(data_en), .data_wr(data_wr), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_strb(data_strb), .data_rdata(data_rdata),
    .data_ready(data_ready), .data_err(data_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_strb(mem_strb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    aresetn = 1'b0; srst = 1'b0;
    inst_en = 1'b0; inst_addr = '0;
    data_en = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0; data_strb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    step(); step();
    check("rst_mem_en",     32'(mem_en), 0);
    check("rst_mem_addr",   32'(mem_addr), 0);
    check("rst_mem_wdata",  mem_wdata, 0);
    check("rst_inst_ready", 32'(inst_ready), 0);
    check("rst_data_ready", 32'(data_ready), 0);
    check("rst_inst_rdata", inst_rdata, 0);
    aresetn = 1'b1;
    step();

    // Lone fetch, zero-wait memory
    inst_en = 1'b1; inst_addr = 16'h0040;
    step();
    check("fetch_mem_en",   32'(mem_en), 1);
    check("fetch_mem_wr",   32'(mem_wr), 0);
    check("fetch_mem_addr", 32'(mem_addr), 32'h0040);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    #1;
    check("fetch_ready",    32'(inst_ready), 1);
    check("fetch_rdata",    inst_rdata, 32'h0000_0013);
    check("fetch_err",      32'(inst_err), 0);
    check("fetch_dready",   32'(data_ready), 0);
    check("fetch_drdata",   data_rdata, 0);
    inst_en = 1'b0;
    step();
    mem_ready = 1'b0; mem_rdata = '0;
    #1;
    check("fetch_done_en",  32'(mem_en), 0);
    check("fetch_done_rdy", 32'(inst_ready), 0);

    // Store with three wait cycles; request fields changed after grant
    data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h1000;
    data_wdata = 32'hDEAD_BEEF; data_strb = 4'hF;
    step();
    data_addr = 16'h2222; data_wdata = 32'h1111_1111; data_strb = 4'h1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_ready = 1'b1;
        #1;
      end
      check("store_en",    32'(mem_en), 1);
      check("store_wr",    32'(mem_wr), 1);
      check("store_addr",  32'(mem_addr), 32'h1000);
      check("store_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("store_strb",  32'(mem_strb), 32'hF);
      check("store_ready", 32'(data_ready), (i == 3) ? 32'd1 : 32'd0);
      check("store_iready", 32'(inst_ready), 0);
      if (i == 3) check("store_err", 32'(data_err), 0);
      else        step();
    end
    data_en = 1'b0;
    step();
    mem_ready = 1'b0;
    #1;
    check("store_done_en",  32'(mem_en), 0);
    check("store_done_rdy", 32'(data_ready), 0);

    // Synchronous reset restores the DATA-first tie preference
    srst = 1'b1;
    step();
    srst = 1'b0;
    inst_en = 1'b1; inst_addr = 16'h0080;
    data_en = 1'b1; data_wr = 1'b0; data_addr = 16'h3000;
    for (int i = 0; i < 4; i++) begin
      step();
      check("tie_en",   32'(mem_en), 1);
      check("tie_addr", 32'(mem_addr), (i % 2 == 0) ? 32'h3000 : 32'h0080);
      mem_ready = 1'b1; mem_rdata = 32'h100 + 32'(i);
      #1;
      check("tie_dready", 32'(data_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("tie_iready", 32'(inst_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      check("tie_other_rdata", (i % 2 == 0) ? inst_rdata : data_rdata, 0);
      check("tie_own_rdata",   (i % 2 == 0) ? data_rdata : inst_rdata, 32'h100 + 32'(i));
      step();
      mem_ready = 1'b0;
      #1;
      check("tie_idle_en", 32'(mem_en), 0);
      if (i == 3) begin
        inst_en = 1'b0; data_en = 1'b0;
      end
    end
    step();

    // Watchdog abort on a fetch
    inst_en = 1'b1; inst_addr = 16'h0044; mem_rdata = 32'hFFFF_FFFF;
    step();
    for (int c = 1; c <= 4; c++) begin
      check("to_wait_ready", 32'(inst_ready), 0);
      check("to_wait_en",    32'(mem_en), 1);
      step();
    end
    check("to_ready", 32'(inst_ready), 1);
    check("to_err",   32'(inst_err), 1);
    check("to_rdata", inst_rdata, 0);
    inst_en = 1'b0;
    step();
    check("to_after_en",    32'(mem_en), 0);
    check("to_after_ready", 32'(inst_ready), 0);

    // mem_ready in the timeout cycle completes normally
    data_en = 1'b1; data_wr = 1'b0; data_addr = 16'h0500;
    step();
    for (int c = 1; c <= 4; c++) begin
      check("bnd_wait_ready", 32'(data_ready), 0);
      step();
    end
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    check("bnd_ready", 32'(data_ready), 1);
    check("bnd_err",   32'(data_err), 0);
    check("bnd_rdata", data_rdata, 32'hCAFE_F00D);
    data_en = 1'b0;
    step();
    mem_ready = 1'b0;
    #1;
    check("bnd_after_en", 32'(mem_en), 0);

    // Asynchronous reset while DATA waits
    data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h0600;
    step();
    check("ar_granted", 32'(mem_en), 1);
    step();
    aresetn = 1'b0;
    #1;
    check("ar_en_drop", 32'(mem_en), 0);
    check("ar_dready",  32'(data_ready), 0);
    data_en = 1'b0;
    step();
    check("ar_hold_dready", 32'(data_ready), 0);
    aresetn = 1'b1;
    inst_en = 1'b1; inst_addr = 16'h0090;
    data_en = 1'b1; data_wr = 1'b0; data_addr = 16'h0700;
    step();
    check("ar_tie_addr", 32'(mem_addr), 32'h0700);
    mem_ready = 1'b1;
    #1;
    check("ar_tie_dready", 32'(data_ready), 1);
    inst_en = 1'b0; data_en = 1'b0;
    step();
    mem_ready = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/friscv_mem_arbiter.md
# friscv_mem_arbiter

Shares a single memory port between the instruction-fetch interface of `friscv_rv32i_control` and the data load/store interface of the ALU. It arbitrates with round-robin fairness and allows one transaction in flight. The block registers the winning request onto the memory port and routes the response back to the owner. A watchdog aborts any access the memory does not complete within a bounded number of cycles.

## Interface
- `ADDRW`, 16: address width of all three interfaces.
- `XLEN`, 32: data width; strobe width is XLEN/8.
- `TIMEOUT`, 255: cycles waited for `mem_ready` before abort; 0 disables the watchdog.

- `aclk`  in  1  clock; all logic is rising-edge.
- `aresetn`  in  1  asynchronous active-low reset.
- `srst`  in  1  synchronous active-high reset; same effect as `aresetn`.
- `inst_en`  in  1  fetch request.
- `inst_addr`  in  ADDRW  fetch address.
- `inst_rdata`  out  XLEN  fetched word.
- `inst_ready`  out  1  fetch completion.
- `inst_err`  out  1  fetch aborted by timeout; valid only with `inst_ready`.
- `data_en`  in  1  load/store request.
- `data_wr`  in  1  1 = store, 0 = load.
- `data_addr`  in  ADDRW  load/store address.
- `data_wdata`  in  XLEN  store data.
- `data_strb`  in  XLEN/8  store byte enables.
- `data_rdata`  out  XLEN  load data.
- `data_ready`  out  1  load/store completion.
- `data_err`  out  1  load/store aborted by timeout; valid only with `data_ready`.
- `mem_en`  out  1  memory request, registered.
- `mem_wr`  out  1  registered write flag.
- `mem_addr`  out  ADDRW  registered address.
- `mem_wdata`  out  XLEN  registered write data.
- `mem_strb`  out  XLEN/8  registered strobes.
- `mem_rdata`  in  XLEN  memory read data; valid with `mem_ready`.
- `mem_ready`  in  1  memory completion.

## Operation
- FSM states: IDLE, INST (fetch granted), DATA (load/store granted). Reset state is IDLE.
- The `last_grant` register resets to INST, so the data port wins the first tie.
- Arbitration in IDLE:
  - Only one enable high: that requester is granted.
  - Both enables high: the requester not equal to `last_grant` is granted.
  - Neither enable high: the FSM stays in IDLE.
- On a grant edge, the block captures the request and sets `mem_en` to 1:
  - Fetch: `mem_addr` = `inst_addr`, `mem_wr` = 0, `mem_wdata` = 0, `mem_strb` = 0.
  - Data: `mem_addr`, `mem_wr`, `mem_wdata`, `mem_strb` are taken from the data port.
- In INST or DATA, all `mem_*` outputs are held stable until completion. Requester inputs are not resampled.
- Completion (`mem_ready` = 1 while granted):
  - The owner's `*_ready` is 1 in the same cycle (combinational).
  - The owner's `*_rdata` = `mem_rdata`; `*_err` = 0.
  - At the next edge: `mem_en` goes to 0, the FSM returns to IDLE, and `last_grant` becomes the owner.
- Watchdog (`TIMEOUT` > 0):
  - Counter clears on grant and increments each granted cycle with `mem_ready` = 0.
  - When the count equals `TIMEOUT`, the owner's `*_ready` and `*_err` are 1 and `*_rdata` = 0. At that edge `mem_en` drops and the FSM returns to IDLE.
  - `mem_ready` arriving in the timeout cycle takes priority: normal completion, `*_err` = 0.
- `*_rdata` of the non-owning port is 0. Its `*_ready` and `*_err` are 0.
- A requester that drops `*_en` mid-transaction does not cancel it. The memory access completes and `*_ready` still pulses.
- Requesters hold `*_en` and request fields until `*_ready`. In the `*_ready` cycle they either drop `*_en` or present the next request.

## Timing
- Reset values: `mem_en`, `mem_wr`, `mem_addr`, `mem_wdata`, `mem_strb` = 0. All `*_ready`, `*_err`, `*_rdata` = 0.
- `aresetn` low mid-transaction: `mem_en` drops immediately (asynchronously), no `*_ready` is issued, and `last_grant` returns to INST.
- `srst` mid-transaction: the same clearing takes effect at the next edge.
- Latency, with `*_en` high before edge k and the FSM in IDLE:
  - `mem_en` is 1 after edge k.
  - With zero-wait memory, `*_ready` is 1 in the cycle after edge k.
- After each completion the FSM spends exactly one cycle in IDLE before the next `mem_en`. Peak throughput is one access per 2 cycles.
- A request held in IDLE is granted at the next edge; there is no extra decode cycle.
- `*_ready` is a single-cycle pulse per transaction.

## Test plan
- Lone fetch: `inst_en`=1, `inst_addr`=0x0040, memory answers 0x00000013 with zero wait → `mem_en`=1, `mem_wr`=0, `mem_addr`=0x0040 after first edge; `inst_ready`=1 and `inst_rdata`=0x00000013 the next cycle.
- Store: `data_en`=1, `data_wr`=1, addr 0x1000, wdata 0xDEADBEEF, strb 0xF, `mem_ready` after 3 wait cycles → `mem_*` stable for 4 cycles; `data_ready`=1 once; `inst_ready` stays 0.
- Tie after reset: both enables held high continuously, zero-wait memory → grant order DATA, INST, DATA, INST; `mem_en` toggles 1,0,1,0,…
- Timeout: `TIMEOUT`=4, `mem_ready` held 0 → `inst_ready`=1, `inst_err`=1, `inst_rdata`=0 on the 5th granted cycle; `mem_en`=0 afterwards.
- Boundary: `TIMEOUT`=4, `mem_ready`=1 exactly in the 5th granted cycle → normal completion with `data_err`=0.
- Reset: `aresetn` pulsed low while DATA is granted and waiting → `mem_en`=0 immediately, no `data_ready`; afterwards a tie grants DATA first.
